// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RISC-V core: ALU op classes, opcodes,
// default widths and the control word used when the pipeline inserts a bubble.
package core_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        ALUOP_I  = 2'b00,
        ALUOP_S  = 2'b01,
        ALUOP_R  = 2'b10,
        ALUOP_SB = 2'b11
    } aluop_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic   reg_write;
        logic   mem_to_reg;
        logic   mem_read;
        logic   mem_write;
        logic   alu_src;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;

    // A bubble must not write registers or memory; the I-type ALU class is harmless.
    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        branch:     1'b0,
        alu_op:     ALUOP_I
    };

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a valid load in EX whose rd matches either
// source register of the instruction currently in decode.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              mem_read_ex_i,
    input  logic              valid_ex_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    input  logic [REG_AW-1:0] rs1_id_i,
    input  logic [REG_AW-1:0] rs2_id_i,
    output logic              hazard_o
);

    // Both rs fields are compared regardless of format; an I-type false hit only costs a bubble.
    assign hazard_o = mem_read_ex_i & valid_ex_i & (rd_ex_i != '0)
                    & ((rd_ex_i == rs1_id_i) | (rd_ex_i == rs2_id_i));

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with integrated load-use stall, flush bubbles and a
// saturating bubble counter for performance debug.
module idex_stage
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic              Branch_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] PC_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        funct_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic              Branch_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] PC_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        funct_o,
    output logic [REG_AW-1:0] RS1addr_o,
    output logic [REG_AW-1:0] RS2addr_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              valid_o,
    output logic              NoOp_o,
    output logic              PCWrite_o,
    output logic              IFIDStall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rs1data_q, rs1data_d;
    logic [DATA_W-1:0] rs2data_q, rs2data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [9:0]        funct_q, funct_d;
    logic [REG_AW-1:0] rs1addr_q, rs1addr_d;
    logic [REG_AW-1:0] rs2addr_q, rs2addr_d;
    logic [REG_AW-1:0] rdaddr_q, rdaddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .mem_read_ex_i (ctrl_q.mem_read),
        .valid_ex_i    (valid_q),
        .rd_ex_i       (rdaddr_q),
        .rs1_id_i      (RS1addr_i),
        .rs2_id_i      (RS2addr_i),
        .hazard_o      (hazard)
    );

    assign NoOp_o      = hazard;
    assign PCWrite_o   = ~hazard & ~stall_i;
    assign IFIDStall_o = hazard | stall_i;

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latch).
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1data_d = rs1data_q;
        rs2data_d = rs2data_q;
        imm_d     = imm_q;
        funct_d   = funct_q;
        rs1addr_d = rs1addr_q;
        rs2addr_d = rs2addr_q;
        rdaddr_d  = rdaddr_q;
        cnt_d     = cnt_q;
        if (!stall_i) begin
            pc_d      = PC_i;
            rs1data_d = RS1data_i;
            rs2data_d = RS2data_i;
            imm_d     = Imm_i;
            funct_d   = funct_i;
            rs1addr_d = RS1addr_i;
            rs2addr_d = RS2addr_i;
            if (flush_i || hazard) begin
                ctrl_d   = CTRL_BUBBLE;
                valid_d  = 1'b0;
                rdaddr_d = '0;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ctrl_d = '{
                    reg_write:  RegWrite_i,
                    mem_to_reg: MemtoReg_i,
                    mem_read:   MemRead_i,
                    mem_write:  MemWrite_i,
                    alu_src:    ALUSrc_i,
                    branch:     Branch_i,
                    alu_op:     aluop_e'(ALUOp_i)
                };
                valid_d  = 1'b1;
                rdaddr_d = RDaddr_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1data_q <= '0;
            rs2data_q <= '0;
            imm_q     <= '0;
            funct_q   <= '0;
            rs1addr_q <= '0;
            rs2addr_q <= '0;
            rdaddr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1data_q <= rs1data_d;
            rs2data_q <= rs2data_d;
            imm_q     <= imm_d;
            funct_q   <= funct_d;
            rs1addr_q <= rs1addr_d;
            rs2addr_q <= rs2addr_d;
            rdaddr_q  <= rdaddr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign RegWrite_o   = ctrl_q.reg_write;
    assign MemtoReg_o   = ctrl_q.mem_to_reg;
    assign MemRead_o    = ctrl_q.mem_read;
    assign MemWrite_o   = ctrl_q.mem_write;
    assign ALUSrc_o     = ctrl_q.alu_src;
    assign Branch_o     = ctrl_q.branch;
    assign ALUOp_o      = ctrl_q.alu_op;
    assign valid_o      = valid_q;
    assign PC_o         = pc_q;
    assign RS1data_o    = rs1data_q;
    assign RS2data_o    = rs2data_q;
    assign Imm_o        = imm_q;
    assign funct_o      = funct_q;
    assign RS1addr_o    = rs1addr_q;
    assign RS2addr_o    = rs2addr_q;
    assign RDaddr_o     = rdaddr_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: reset, pass-through, load-use, stall/flush
// interplay and counter saturation on a narrow-counter second instance.
module tb_idex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] PC_i, RS1data_i, RS2data_i, Imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;

    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] PC_o, RS1data_o, RS2data_o, Imm_o;
    logic [9:0]  funct_o;
    logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
    logic        valid_o, NoOp_o, PCWrite_o, IFIDStall_o;
    logic [15:0] bubble_cnt_o;

    logic        s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_ALUSrc_o, s_Branch_o;
    logic [1:0]  s_ALUOp_o;
    logic [31:0] s_PC_o, s_RS1data_o, s_RS2data_o, s_Imm_o;
    logic [9:0]  s_funct_o;
    logic [4:0]  s_RS1addr_o, s_RS2addr_o, s_RDaddr_o;
    logic        s_valid_o, s_NoOp_o, s_PCWrite_o, s_IFIDStall_o;
    logic [1:0]  s_bubble_cnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    idex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .ALUOp_i(ALUOp_i),
        .PC_i(PC_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i),
        .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o),
        .PC_o(PC_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o),
        .funct_o(funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .valid_o(valid_o), .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDStall_o(IFIDStall_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    idex_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .ALUOp_i(ALUOp_i),
        .PC_i(PC_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i),
        .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_o(s_RegWrite_o), .MemtoReg_o(s_MemtoReg_o), .MemRead_o(s_MemRead_o),
        .MemWrite_o(s_MemWrite_o), .ALUSrc_o(s_ALUSrc_o), .Branch_o(s_Branch_o), .ALUOp_o(s_ALUOp_o),
        .PC_o(s_PC_o), .RS1data_o(s_RS1data_o), .RS2data_o(s_RS2data_o), .Imm_o(s_Imm_o),
        .funct_o(s_funct_o), .RS1addr_o(s_RS1addr_o), .RS2addr_o(s_RS2addr_o), .RDaddr_o(s_RDaddr_o),
        .valid_o(s_valid_o), .NoOp_o(s_NoOp_o), .PCWrite_o(s_PCWrite_o), .IFIDStall_o(s_IFIDStall_o),
        .bubble_cnt_o(s_bubble_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it before the next stimulus or check.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic rw, input logic mtr, input logic mr,
                         input logic mw, input logic as, input logic br, input logic [1:0] aop,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [9:0] fn, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd);
        PC_i = pc; RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
        ALUSrc_i = as; Branch_i = br; ALUOp_i = aop; RS1data_i = d1; RS2data_i = d2;
        Imm_i = imm; funct_i = fn; RS1addr_i = a1; RS2addr_i = a2; RDaddr_i = rd;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive(32'hDEAD, 1, 1, 1, 1, 1, 1, 2'b11, 32'h1, 32'h2, 32'h3, 10'h3FF, 5'd5, 5'd5, 5'd5);
        tick();
        tick();
        check("rst_ctrl", {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, ALUOp_o}, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", {PC_o, RS1data_o}, 0);
        check("rst_addr", {RDaddr_o, RS1addr_o, RS2addr_o, funct_o}, 0);
        check("rst_cnt", bubble_cnt_o, 0);
        check("rst_hz", {NoOp_o, PCWrite_o, IFIDStall_o}, 3'b010);

        // R-type pass-through
        rst_i = 1'b0;
        drive(32'h100, 1, 0, 0, 0, 0, 0, 2'b10, 32'h11, 32'h22, 32'h0, 10'h000, 5'd1, 5'd2, 5'd6);
        tick();
        check("pt_ctrl", {RegWrite_o, MemRead_o, ALUOp_o}, 4'b1010);
        check("pt_data", {PC_o, RS1data_o, RS2data_o}, {32'h100, 32'h11, 32'h22});
        check("pt_addr", {RS1addr_o, RS2addr_o, RDaddr_o}, {5'd1, 5'd2, 5'd6});
        check("pt_valid", valid_o, 1);

        // lw x5 into EX, then add using x5 as rs2
        drive(32'h104, 1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h8, 10'h002, 5'd2, 5'd0, 5'd5);
        tick();
        check("lw_loaded", {MemRead_o, MemtoReg_o, RDaddr_o, valid_o}, {1'b1, 1'b1, 5'd5, 1'b1});
        drive(32'h108, 1, 0, 0, 0, 0, 0, 2'b10, 32'h3, 32'h4, 32'h0, 10'h000, 5'd3, 5'd5, 5'd7);
        check("lu_hz", {NoOp_o, PCWrite_o, IFIDStall_o}, 3'b101);
        tick();
        check("lu_bubble", {valid_o, RegWrite_o, MemRead_o, MemtoReg_o, RDaddr_o}, 0);
        check("lu_cnt", bubble_cnt_o, 1);
        check("lu_clear", {NoOp_o, PCWrite_o, IFIDStall_o}, 3'b010);
        tick();
        check("lu_replay", {valid_o, RDaddr_o, RegWrite_o}, {1'b1, 5'd7, 1'b1});

        // lw to x0 followed by reader of x0: no hazard
        drive(32'h10C, 1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 10'h002, 5'd1, 5'd0, 5'd0);
        tick();
        drive(32'h110, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h000, 5'd0, 5'd0, 5'd8);
        check("x0_nohz", NoOp_o, 0);

        // non-load writes x5, then a use of x5: no hazard
        drive(32'h114, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h000, 5'd1, 5'd2, 5'd5);
        tick();
        drive(32'h118, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h000, 5'd5, 5'd5, 5'd9);
        check("nonload_nohz", {NoOp_o, PCWrite_o}, 2'b01);
        tick();
        check("nonload_pass", {valid_o, RDaddr_o, bubble_cnt_o}, {1'b1, 5'd9, 16'd1});

        // stall and flush together: frozen for 3 edges
        drive(32'h200, 1, 0, 0, 0, 0, 0, 2'b10, 32'hAA, 32'h0, 32'h0, 10'h000, 5'd1, 5'd2, 5'd10);
        tick();
        stall_i = 1'b1; flush_i = 1'b1;
        drive(32'h300, 1, 0, 0, 0, 0, 0, 2'b10, 32'hBB, 32'h0, 32'h0, 10'h000, 5'd3, 5'd4, 5'd11);
        check("stall_hz", {NoOp_o, PCWrite_o, IFIDStall_o}, 3'b001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_frozen", {PC_o, RS1data_o, RDaddr_o, valid_o, bubble_cnt_o},
                  {32'h200, 32'hAA, 5'd10, 1'b1, 16'd1});
        end
        stall_i = 1'b0;
        tick();
        check("flush_bubble", {valid_o, RegWrite_o, RDaddr_o, bubble_cnt_o}, {1'b0, 1'b0, 5'd0, 16'd2});
        flush_i = 1'b0;
        tick();
        check("flush_resume", {valid_o, RDaddr_o, PC_o}, {1'b1, 5'd11, 32'h300});

        // flush and hazard together: one bubble, count +1
        drive(32'h304, 1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h4, 10'h002, 5'd1, 5'd0, 5'd12);
        tick();
        flush_i = 1'b1;
        drive(32'h308, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h000, 5'd12, 5'd1, 5'd13);
        check("fh_hz", NoOp_o, 1);
        tick();
        check("fh_bubble", {valid_o, bubble_cnt_o}, {1'b0, 16'd3});
        flush_i = 1'b0;

        // hazard held through a stall
        drive(32'h30C, 1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h4, 10'h002, 5'd1, 5'd0, 5'd13);
        tick();
        stall_i = 1'b1;
        drive(32'h310, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h000, 5'd2, 5'd13, 5'd14);
        check("sh_hz", {NoOp_o, PCWrite_o, IFIDStall_o}, 3'b101);
        tick();
        check("sh_held", {NoOp_o, valid_o, MemRead_o, bubble_cnt_o}, {1'b1, 1'b1, 1'b1, 16'd3});
        stall_i = 1'b0;
        tick();
        check("sh_bubble", {valid_o, NoOp_o, bubble_cnt_o}, {1'b0, 1'b0, 16'd4});

        // reset in the middle of a hazard
        drive(32'h314, 1, 1, 1, 0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h4, 10'h002, 5'd1, 5'd0, 5'd14);
        tick();
        drive(32'h318, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h000, 5'd14, 5'd2, 5'd15);
        check("rh_hz", NoOp_o, 1);
        rst_i = 1'b1;
        tick();
        check("rh_clear", {NoOp_o, PCWrite_o, valid_o, bubble_cnt_o}, {1'b0, 1'b1, 1'b0, 16'd0});
        rst_i = 1'b0;

        // saturation on the 2-bit counter instance
        flush_i = 1'b1;
        tick();
        check("sat_1", s_bubble_cnt_o, 2'd1);
        tick();
        check("sat_2", s_bubble_cnt_o, 2'd2);
        tick();
        check("sat_3", s_bubble_cnt_o, 2'd3);
        tick();
        check("sat_4", s_bubble_cnt_o, 2'd3);
        tick();
        check("sat_5", s_bubble_cnt_o, 2'd3);
        check("wide_5", bubble_cnt_o, 16'd5);
        flush_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
